// File: rtl/rle1_chan_driver_pkg.sv
// Shared widths and TX state encoding for the rle1 channel driver.
// Everything else in the driver imports this package.
package rle1_chan_pkg;

  localparam int ENC_IN_W  = 2;
  localparam int ENC_OUT_W = 6;
  localparam int DEC_IN_W  = 6;
  localparam int DEC_OUT_W = 2;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_LOAD = 1'b1
  } tx_state_e;

endpackage

// File: rtl/rle1_chan_driver_if.sv
// Pin-side rle1 channel bundle: one TX lane towards the DUT, one RX lane back.
// Handshake: a beat transfers on a rising edge where vld && rdy; once vld is
// high, data and vld hold until that edge. rdy may change freely.
interface rle1_chan_driver_if #(
  parameter int TX_W = 2,
  parameter int RX_W = 6
);
  logic [TX_W-1:0] ch_tx_data;
  logic            ch_tx_vld;
  logic            ch_tx_rdy;
  logic [RX_W-1:0] ch_rx_data;
  logic            ch_rx_vld;
  logic            ch_rx_rdy;

  modport master (
    output ch_tx_data, ch_tx_vld, ch_rx_rdy,
    input  ch_tx_rdy, ch_rx_data, ch_rx_vld
  );

  modport slave (
    input  ch_tx_data, ch_tx_vld, ch_rx_rdy,
    output ch_tx_rdy, ch_rx_data, ch_rx_vld
  );
endinterface

// File: rtl/rle1_chan_driver_fifo.sv
// Show-ahead synchronous FIFO; head_o is the oldest entry (0 when empty).
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module chan_sync_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // A push on a full FIFO is dropped even if a pop frees a slot the same edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end
endmodule

// File: rtl/rle1_chan_driver.sv
// Host-side initiator for an rle1 channel: TX FIFO feeding a registered
// output stage, RX FIFO capturing the return lane, sticky err and beat counters.
module rle1_chan_driver
  import rle1_chan_pkg::*;
#(
  parameter int TX_W  = ENC_IN_W,
  parameter int RX_W  = ENC_OUT_W,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              host_wr_en,
  input  logic [TX_W-1:0]   host_wr_data,
  output logic              host_full,
  input  logic              host_rd_en,
  output logic [RX_W-1:0]   host_rd_data,
  output logic              host_empty,
  output logic              err,
  input  logic              err_clr,
  output logic [15:0]       tx_count,
  output logic [15:0]       rx_count,
  output tx_state_e         tx_state,
  rle1_chan_driver_if.master ch
);
  tx_state_e       state_q, state_d;
  logic [TX_W-1:0] data_q, data_d;
  logic [TX_W-1:0] tx_head;
  logic            tx_empty, tx_full, tx_load, tx_hs;
  logic            rx_full, rx_cap, rx_en_q;
  logic            err_q, err_d;
  logic [15:0]     tx_count_q, rx_count_q;

  chan_sync_fifo #(.W(TX_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(reset_n),
    .push_i(host_wr_en), .push_data_i(host_wr_data),
    .pop_i(tx_load), .head_o(tx_head),
    .full_o(tx_full), .empty_o(tx_empty)
  );

  chan_sync_fifo #(.W(RX_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(reset_n),
    .push_i(rx_cap), .push_data_i(ch.ch_rx_data),
    .pop_i(host_rd_en), .head_o(host_rd_data),
    .full_o(rx_full), .empty_o(host_empty)
  );

  assign ch.ch_tx_vld  = (state_q == TX_LOAD);
  assign ch.ch_tx_data = data_q;
  assign tx_hs         = ch.ch_tx_vld && ch.ch_tx_rdy;
  // rx_en_q keeps rdy low while reset is held and for the first edge after.
  assign ch.ch_rx_rdy  = rx_en_q && !rx_full;
  assign rx_cap        = ch.ch_rx_vld && ch.ch_rx_rdy;

  assign host_full = tx_full;
  assign err       = err_q;
  assign tx_count  = tx_count_q;
  assign rx_count  = rx_count_q;
  assign tx_state  = state_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tx_load = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (run && !tx_empty) begin
          tx_load = 1'b1;
          state_d = TX_LOAD;
        end
      end
      TX_LOAD: begin
        // run only gates the next load; the presented symbol waits for rdy.
        if (tx_hs) begin
          if (run && !tx_empty) tx_load = 1'b1;
          else                  state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
    if (tx_load) data_d = tx_head;
  end

  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if ((host_wr_en && tx_full) || (host_rd_en && host_empty)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= TX_IDLE;
      data_q     <= '0;
      rx_en_q    <= 1'b0;
      err_q      <= 1'b0;
      tx_count_q <= '0;
      rx_count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rx_en_q <= 1'b1;
      err_q   <= err_d;
      if (tx_hs)  tx_count_q <= tx_count_q + 16'd1;
      if (rx_cap) rx_count_q <= rx_count_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_rle1_chan_driver.sv
// Self-checking bench for rle1_chan_driver: host pushes/pops against a
// queue-based reference of the two FIFOs and the channel beat rules.
module tb_rle1_chan_driver;
  import rle1_chan_pkg::*;

  localparam int TX_W  = ENC_IN_W;
  localparam int RX_W  = ENC_OUT_W;
  localparam int DEPTH = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic            run, host_wr_en, host_rd_en, err_clr;
  logic [TX_W-1:0] host_wr_data;
  logic [RX_W-1:0] host_rd_data;
  logic            host_full, host_empty, err;
  logic [15:0]     tx_count, rx_count;
  tx_state_e       tx_state;

  rle1_chan_driver_if #(.TX_W(TX_W), .RX_W(RX_W)) ch_if ();

  rle1_chan_driver #(.TX_W(TX_W), .RX_W(RX_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .host_wr_en(host_wr_en), .host_wr_data(host_wr_data), .host_full(host_full),
    .host_rd_en(host_rd_en), .host_rd_data(host_rd_data), .host_empty(host_empty),
    .err(err), .err_clr(err_clr), .tx_count(tx_count), .rx_count(rx_count),
    .tx_state(tx_state), .ch(ch_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: accepted TX symbols, observed TX beats, RX FIFO contents
  logic [TX_W-1:0] exp_q[$];
  logic [TX_W-1:0] hs_q[$];
  logic [RX_W-1:0] rx_q[$];
  logic [15:0]     exp_tx_cnt = '0;
  logic [15:0]     exp_rx_cnt = '0;

  task automatic model_clear();
    exp_q.delete(); hs_q.delete(); rx_q.delete();
    exp_tx_cnt = '0; exp_rx_cnt = '0;
  endtask

  task automatic idle_inputs();
    run = 1'b0; host_wr_en = 1'b0; host_wr_data = '0; host_rd_en = 1'b0;
    err_clr = 1'b0; ch_if.ch_tx_rdy = 1'b0; ch_if.ch_rx_vld = 1'b0; ch_if.ch_rx_data = '0;
  endtask

  // One clock: note the beats that complete at this edge, then settle #1 after it.
  task automatic tick();
    bit txh, cap, pop;
    logic [TX_W-1:0] td;
    logic [RX_W-1:0] rd;
    txh = ch_if.ch_tx_vld && ch_if.ch_tx_rdy;
    cap = ch_if.ch_rx_vld && ch_if.ch_rx_rdy;
    pop = host_rd_en && (rx_q.size() > 0);
    td  = ch_if.ch_tx_data;
    rd  = ch_if.ch_rx_data;
    @(posedge clk);
    #1;
    if (txh) begin hs_q.push_back(td); exp_tx_cnt++; end
    if (pop) void'(rx_q.pop_front());
    if (cap) begin rx_q.push_back(rd); exp_rx_cnt++; end
  endtask

  task automatic drain_tx(input int budget, output bit ok);
    run = 1'b1; ch_if.ch_tx_rdy = 1'b1; host_wr_en = 1'b0; ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (hs_q.size() == exp_q.size() && !ch_if.ch_tx_vld) begin ok = 1'b1; break; end
      tick();
    end
    if (hs_q.size() == exp_q.size() && !ch_if.ch_tx_vld) ok = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 reset_n = 1'b0;
    #2;
    n_tests++;
    if (ch_if.ch_tx_vld !== 1'b0 || ch_if.ch_tx_data !== '0 || ch_if.ch_rx_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_chan: vld=%b data=%0h rx_rdy=%b, want 0/0/0",
               ch_if.ch_tx_vld, ch_if.ch_tx_data, ch_if.ch_rx_rdy);
    end
    n_tests++;
    if (err !== 1'b0 || host_full !== 1'b0 || host_empty !== 1'b1 || host_rd_data !== '0 ||
        tx_count !== 16'd0 || rx_count !== 16'd0 || tx_state !== TX_IDLE) begin
      n_fail++;
      $display("FAIL reset_host: err=%b full=%b empty=%b rd=%0h txc=%0d rxc=%0d st=%0d",
               err, host_full, host_empty, host_rd_data, tx_count, rx_count, tx_state);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_clear();
    tick();
    n_tests++;
    if (ch_if.ch_rx_rdy !== 1'b1) begin
      n_fail++; $display("FAIL rx_rdy_after_reset: got %b want 1", ch_if.ch_rx_rdy);
    end
  endtask

  task automatic test_back_to_back();
    logic [TX_W-1:0] s;
    bit ok, good;
    int n;
    run = 1'b1; ch_if.ch_tx_rdy = 1'b1;
    host_wr_en = 1'b1; host_wr_data = 2'd1; exp_q.push_back(2'd1); tick();
    n_tests++;
    if (ch_if.ch_tx_vld !== 1'b0) begin
      n_fail++; $display("FAIL latency_e0: vld=%b want 0", ch_if.ch_tx_vld);
    end
    for (int k = 1; k <= 3; k++) begin
      if (k < 3) begin
        s = TX_W'(k + 1);
        host_wr_data = s; exp_q.push_back(s);
      end else host_wr_en = 1'b0;
      tick();
      n_tests++;
      if (ch_if.ch_tx_vld !== 1'b1 || ch_if.ch_tx_data !== TX_W'(k)) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: vld=%b data=%0d want 1/%0d", k, ch_if.ch_tx_vld, ch_if.ch_tx_data, k);
      end
    end
    tick();
    n_tests++;
    if (ch_if.ch_tx_vld !== 1'b0 || tx_count !== 16'd3) begin
      n_fail++; $display("FAIL b2b_end: vld=%b txc=%0d want 0/3", ch_if.ch_tx_vld, tx_count);
    end
    // random burst with random rdy back-pressure
    n = $urandom_range(4, 6);
    for (int i = 0; i < n; i++) begin
      s = TX_W'($urandom_range(0, 3));
      host_wr_en = 1'b1; host_wr_data = s; exp_q.push_back(s);
      ch_if.ch_tx_rdy = 1'($urandom_range(0, 1));
      tick();
    end
    drain_tx(40, ok);
    good = ok && (hs_q.size() == exp_q.size());
    if (good) foreach (exp_q[i]) if (hs_q[i] !== exp_q[i]) good = 1'b0;
    n_tests++;
    if (!good) begin
      n_fail++; $display("FAIL b2b_order: got %0d beats want %0d (drain ok=%b)", hs_q.size(), exp_q.size(), ok);
    end
    n_tests++;
    if (tx_count !== exp_tx_cnt || exp_tx_cnt !== 16'(3 + n)) begin
      n_fail++; $display("FAIL b2b_count: got %0d want %0d", tx_count, 3 + n);
    end
    exp_q.delete(); hs_q.delete();
  endtask

  task automatic test_stall();
    logic [TX_W-1:0] s, t;
    bit stable, ok;
    s = TX_W'($urandom_range(0, 3)); t = TX_W'($urandom_range(0, 3));
    run = 1'b1; ch_if.ch_tx_rdy = 1'b0;
    host_wr_en = 1'b1; host_wr_data = s; exp_q.push_back(s); tick();
    host_wr_data = t; exp_q.push_back(t); tick();
    host_wr_en = 1'b0;
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) run = 1'b0;
      if (ch_if.ch_tx_vld !== 1'b1 || ch_if.ch_tx_data !== s) stable = 1'b0;
      tick();
    end
    n_tests++;
    if (!stable || ch_if.ch_tx_vld !== 1'b1 || ch_if.ch_tx_data !== s) begin
      n_fail++; $display("FAIL stall_hold: vld=%b data=%0d want 1/%0d", ch_if.ch_tx_vld, ch_if.ch_tx_data, s);
    end
    ch_if.ch_tx_rdy = 1'b1;
    tick(); tick(); tick();
    n_tests++;
    if (ch_if.ch_tx_vld !== 1'b0 || tx_count !== exp_tx_cnt || hs_q.size() != 1) begin
      n_fail++; $display("FAIL stall_no_reload: vld=%b txc=%0d beats=%0d want 0/%0d/1",
                         ch_if.ch_tx_vld, tx_count, hs_q.size(), exp_tx_cnt);
    end
    run = 1'b1; ch_if.ch_tx_rdy = 1'b0; tick();
    n_tests++;
    if (ch_if.ch_tx_vld !== 1'b1 || ch_if.ch_tx_data !== t) begin
      n_fail++; $display("FAIL stall_resume: vld=%b data=%0d want 1/%0d", ch_if.ch_tx_vld, ch_if.ch_tx_data, t);
    end
    drain_tx(10, ok);
    n_tests++;
    if (!ok || hs_q[0] !== s || hs_q[1] !== t) begin
      n_fail++; $display("FAIL stall_order: ok=%b beats=%0d", ok, hs_q.size());
    end
    exp_q.delete(); hs_q.delete();
  endtask

  task automatic test_overflow();
    logic [TX_W-1:0] s;
    bit ok, good;
    run = 1'b0; ch_if.ch_tx_rdy = 1'b0; err_clr = 1'b1; tick(); err_clr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s = TX_W'($urandom_range(0, 3));
      host_wr_en = 1'b1; host_wr_data = s;
      if (i < DEPTH) exp_q.push_back(s);
      tick();
      if (i == DEPTH - 2 || i == DEPTH - 1) begin
        n_tests++;
        if (host_full !== (i == DEPTH - 1) || err !== 1'b0) begin
          n_fail++; $display("FAIL ovf_fill%0d: full=%b err=%b", i + 1, host_full, err);
        end
      end
    end
    host_wr_en = 1'b0;
    n_tests++;
    if (err !== 1'b1 || host_full !== 1'b1) begin
      n_fail++; $display("FAIL ovf_err: err=%b full=%b want 1/1", err, host_full);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: err=%b want 0", err); end
    // push on a full FIFO while the FSM pops the head the same edge
    run = 1'b1; host_wr_en = 1'b1; host_wr_data = TX_W'($urandom_range(0, 3)); tick();
    host_wr_en = 1'b0;
    n_tests++;
    if (err !== 1'b1 || host_full !== 1'b0) begin
      n_fail++; $display("FAIL ovf_no_passthru: err=%b full=%b want 1/0", err, host_full);
    end
    drain_tx(30, ok);
    good = ok && (hs_q.size() == exp_q.size());
    if (good) foreach (exp_q[i]) if (hs_q[i] !== exp_q[i]) good = 1'b0;
    n_tests++;
    if (!good) begin
      n_fail++; $display("FAIL ovf_order: got %0d beats want %0d", hs_q.size(), exp_q.size());
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    exp_q.delete(); hs_q.delete();
  endtask

  task automatic test_rx_fill();
    logic [RX_W-1:0] r[10];
    logic [RX_W-1:0] got[$];
    logic [15:0] base;
    int k;
    bit c, rdy_ok, head_ok, good;
    foreach (r[i]) r[i] = RX_W'($urandom_range(0, 63));
    base = exp_rx_cnt; k = 0; rdy_ok = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      ch_if.ch_rx_vld = 1'b1; ch_if.ch_rx_data = r[k];
      if (ch_if.ch_rx_rdy !== (rx_q.size() < DEPTH)) rdy_ok = 1'b0;
      c = ch_if.ch_rx_rdy;
      tick();
      if (c) k++;
    end
    n_tests++;
    if (!rdy_ok || k != DEPTH || ch_if.ch_rx_rdy !== 1'b0 || rx_count !== base + 16'd8) begin
      n_fail++; $display("FAIL rx_full: rdy=%b k=%0d rxc=%0d want 0/8/%0d", ch_if.ch_rx_rdy, k, rx_count, base + 16'd8);
    end
    n_tests++;
    if (host_rd_data !== r[0] || host_empty !== 1'b0) begin
      n_fail++; $display("FAIL rx_head: got %0h want %0h", host_rd_data, r[0]);
    end
    got.push_back(host_rd_data);
    host_rd_en = 1'b1; tick(); host_rd_en = 1'b0;
    n_tests++;
    if (ch_if.ch_rx_rdy !== 1'b1 || rx_count !== base + 16'd8) begin
      n_fail++; $display("FAIL rx_pop_on_full: rdy=%b rxc=%0d want 1/%0d", ch_if.ch_rx_rdy, rx_count, base + 16'd8);
    end
    tick(); k++;
    n_tests++;
    if (ch_if.ch_rx_rdy !== 1'b0 || rx_count !== base + 16'd9) begin
      n_fail++; $display("FAIL rx_ninth: rdy=%b rxc=%0d want 0/%0d", ch_if.ch_rx_rdy, rx_count, base + 16'd9);
    end
    head_ok = 1'b1;
    for (int cyc = 0; cyc < 24 && got.size() < 10; cyc++) begin
      ch_if.ch_rx_vld = (k < 10); ch_if.ch_rx_data = (k < 10) ? r[k] : '0;
      host_rd_en = (rx_q.size() > 0);
      if (rx_q.size() > 0) begin
        if (host_rd_data !== rx_q[0]) head_ok = 1'b0;
        got.push_back(host_rd_data);
      end
      c = ch_if.ch_rx_vld && ch_if.ch_rx_rdy;
      tick();
      if (c) k++;
    end
    host_rd_en = 1'b0; ch_if.ch_rx_vld = 1'b0;
    good = head_ok && (got.size() == 10);
    if (good) foreach (r[i]) if (got[i] !== r[i]) good = 1'b0;
    n_tests++;
    if (!good) begin n_fail++; $display("FAIL rx_order: popped %0d head_ok=%b", got.size(), head_ok); end
    n_tests++;
    if (host_empty !== 1'b1 || rx_count !== base + 16'd10 || err !== 1'b0) begin
      n_fail++; $display("FAIL rx_end: empty=%b rxc=%0d err=%b want 1/%0d/0", host_empty, rx_count, err, base + 16'd10);
    end
  endtask

  task automatic test_pop_empty();
    host_rd_en = 1'b1; tick(); host_rd_en = 1'b0;
    n_tests++;
    if (err !== 1'b1 || host_empty !== 1'b1 || host_rd_data !== '0 ||
        tx_count !== exp_tx_cnt || rx_count !== exp_rx_cnt) begin
      n_fail++; $display("FAIL pop_empty: err=%b empty=%b txc=%0d rxc=%0d want 1/1/%0d/%0d",
                         err, host_empty, tx_count, rx_count, exp_tx_cnt, exp_rx_cnt);
    end
    err_clr = 1'b1; host_rd_en = 1'b1; tick(); host_rd_en = 1'b0;
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL clr_vs_event: err=%b want 1", err); end
    tick(); err_clr = 1'b0;
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: err=%b want 0", err); end
  endtask

  task automatic test_reset_mid();
    logic [TX_W-1:0] stream[4];
    logic [TX_W-1:0] s;
    bit ok, good;
    stream[0] = 2'd0; stream[1] = 2'd0; stream[2] = 2'd0; stream[3] = 2'd1;
    for (int i = 0; i < 3; i++) begin
      ch_if.ch_rx_vld = 1'b1; ch_if.ch_rx_data = RX_W'($urandom_range(1, 63)); tick();
    end
    ch_if.ch_rx_vld = 1'b0;
    run = 1'b1; ch_if.ch_tx_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_wr_en = 1'b1; host_wr_data = stream[i]; tick();
    end
    host_wr_en = 1'b0; tick();
    n_tests++;
    if (ch_if.ch_tx_vld !== 1'b1 || ch_if.ch_tx_data !== 2'd1 || host_empty !== 1'b0) begin
      n_fail++; $display("FAIL mid_pre: vld=%b data=%0d empty=%b want 1/1/0", ch_if.ch_tx_vld, ch_if.ch_tx_data, host_empty);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (ch_if.ch_tx_vld !== 1'b0 || ch_if.ch_tx_data !== '0 || ch_if.ch_rx_rdy !== 1'b0 ||
        host_empty !== 1'b1 || host_full !== 1'b0 || host_rd_data !== '0 || err !== 1'b0 ||
        tx_count !== 16'd0 || rx_count !== 16'd0) begin
      n_fail++; $display("FAIL mid_reset: vld=%b data=%0d rdy=%b empty=%b txc=%0d rxc=%0d",
                         ch_if.ch_tx_vld, ch_if.ch_tx_data, ch_if.ch_rx_rdy, host_empty, tx_count, rx_count);
    end
    idle_inputs();
    @(posedge clk); #1 reset_n = 1'b1;
    model_clear();
    tick();
    for (int i = 0; i < 4; i++) begin
      s = TX_W'($urandom_range(0, 3));
      run = 1'b1; host_wr_en = 1'b1; host_wr_data = s; exp_q.push_back(s);
      ch_if.ch_tx_rdy = 1'($urandom_range(0, 1));
      tick();
    end
    drain_tx(30, ok);
    good = ok && (hs_q.size() == 4);
    if (good) foreach (exp_q[i]) if (hs_q[i] !== exp_q[i]) good = 1'b0;
    n_tests++;
    if (!good || tx_count !== 16'd4) begin
      n_fail++; $display("FAIL mid_fresh: beats=%0d txc=%0d want 4/4", hs_q.size(), tx_count);
    end
    exp_q.delete(); hs_q.delete();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_rx_fill();
    test_pop_empty();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
